// File: rtl/operand_decode_pkg.sv
// mips_pkg: ALU operations, MIPS opcode/funct constants, shift encodings and the
// combinational instruction decoder shared by the operand_decode stage.
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // bit0 = arithmetic, bit1 = right, bit2 = variable amount
  localparam logic [2:0] SHIFT_SLL  = 3'b000;
  localparam logic [2:0] SHIFT_NONE = 3'b001;
  localparam logic [2:0] SHIFT_SRL  = 3'b010;
  localparam logic [2:0] SHIFT_SRA  = 3'b011;
  localparam logic [2:0] SHIFT_SLLV = 3'b100;
  localparam logic [2:0] SHIFT_SRLV = 3'b110;
  localparam logic [2:0] SHIFT_SRAV = 3'b111;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [2:0]  shift_type;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d.alu_op     = ALU_ADD;
    d.shift_type = SHIFT_NONE;
    d.use_imm    = 1'b0;
    d.imm        = {{16{ins[15]}}, ins[15:0]};
    d.dest       = ins[15:11];
    d.illegal    = 1'b0;
    case (ins[31:26])
      OP_RTYPE: begin
        case (ins[5:0])
          FN_SLL:  begin d.alu_op = ALU_SLL; d.shift_type = SHIFT_SLL;  end
          FN_SRL:  begin d.alu_op = ALU_SRL; d.shift_type = SHIFT_SRL;  end
          FN_SRA:  begin d.alu_op = ALU_SRA; d.shift_type = SHIFT_SRA;  end
          FN_SLLV: begin d.alu_op = ALU_SLL; d.shift_type = SHIFT_SLLV; end
          FN_SRLV: begin d.alu_op = ALU_SRL; d.shift_type = SHIFT_SRLV; end
          FN_SRAV: begin d.alu_op = ALU_SRA; d.shift_type = SHIFT_SRAV; end
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_ADDU: d.alu_op = ALU_ADDU;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_SUBU: d.alu_op = ALU_SUBU;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_XOR:  d.alu_op = ALU_XOR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          FN_SLTU: d.alu_op = ALU_SLTU;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.use_imm = 1'b1;
        d.dest    = ins[20:16];
        case (ins[31:26])
          OP_ADDI:  d.alu_op = ALU_ADD;
          OP_ADDIU: d.alu_op = ALU_ADDU;
          OP_SLTI:  d.alu_op = ALU_SLT;
          OP_SLTIU: d.alu_op = ALU_SLTU;
          OP_ANDI:  begin d.alu_op = ALU_AND; d.imm = {16'h0, ins[15:0]}; end
          OP_ORI:   begin d.alu_op = ALU_OR;  d.imm = {16'h0, ins[15:0]}; end
          OP_XORI:  begin d.alu_op = ALU_XOR; d.imm = {16'h0, ins[15:0]}; end
          default:  begin d.alu_op = ALU_OR;  d.imm = {ins[15:0], 16'h0}; end
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_decode_if.sv
// Handshake, write-back and decoded-bundle signals of the operand_decode stage.
`default_nettype none

interface operand_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] reg1_data;
  logic [31:0] reg2_data;
  logic [31:0] immediate_data;
  logic [4:0]  shift_ammount;
  logic        use_immediate;
  logic [2:0]  shift_type;
  logic [3:0]  alu_op;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        illegal;

  modport master (
    output in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, reg1_data, reg2_data, immediate_data, shift_ammount,
           use_immediate, shift_type, alu_op, dest_reg, reg_write, illegal
  );

  modport slave (
    input  in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, reg1_data, reg2_data, immediate_data, shift_ammount,
           use_immediate, shift_type, alu_op, dest_reg, reg_write, illegal
  );
endinterface

`default_nettype wire

// File: rtl/operand_decode_regfile.sv
// register_file: 32 x 32-bit, two combinational read ports, one synchronous write
// port, synchronous reset; register 0 is hardwired to zero.
`default_nettype none

module register_file (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        we,
  input  wire logic [4:0]  waddr,
  input  wire logic [31:0] wdata,
  input  wire logic [4:0]  raddr1,
  input  wire logic [4:0]  raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2
);
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];
endmodule

`default_nettype wire

// File: rtl/operand_decode.sv
// operand_decode: one-entry registered MIPS decode/operand-fetch stage.
// Optional build macro OPERAND_DECODE_WB_BYPASS_EN forwards same-cycle write-back data.
`default_nettype none

module operand_decode
  import mips_pkg::*;
(
  input wire logic         clk,
  input wire logic         rst,
  operand_decode_if.slave  bus
);
  logic [4:0]  rs, rt;
  logic [31:0] rf_rs, rf_rt, rs_val, rt_val;
  logic        capture;
  dec_t        dec;

  logic        out_valid_r, use_imm_r, reg_write_r, illegal_r;
  logic [31:0] reg1_r, reg2_r, imm_r;
  logic [4:0]  shamt_r, dest_r;
  logic [2:0]  shift_r;
  logic [3:0]  alu_r;

  assign rs = bus.instr[25:21];
  assign rt = bus.instr[20:16];

  register_file u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.wb_en),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rs),
    .rdata2 (rf_rt)
  );

`ifdef OPERAND_DECODE_WB_BYPASS_EN
  assign rs_val = (bus.wb_en && bus.wb_addr == rs && rs != 5'd0) ? bus.wb_data : rf_rs;
  assign rt_val = (bus.wb_en && bus.wb_addr == rt && rt != 5'd0) ? bus.wb_data : rf_rt;
`else
  assign rs_val = rf_rs;
  assign rt_val = rf_rt;
`endif

  assign dec          = decode(bus.instr);
  assign bus.in_ready = !out_valid_r || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      reg1_r      <= '0;
      reg2_r      <= '0;
      imm_r       <= '0;
      shamt_r     <= '0;
      use_imm_r   <= 1'b0;
      shift_r     <= SHIFT_NONE;
      alu_r       <= '0;
      dest_r      <= '0;
      reg_write_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (bus.flush) begin
      // the instruction presented alongside a flush is dropped
      out_valid_r <= 1'b0;
    end else if (capture) begin
      out_valid_r <= 1'b1;
      reg1_r      <= rs_val;
      reg2_r      <= rt_val;
      imm_r       <= dec.imm;
      shamt_r     <= bus.instr[10:6];
      use_imm_r   <= dec.use_imm;
      shift_r     <= dec.shift_type;
      alu_r       <= dec.alu_op;
      dest_r      <= dec.dest;
      reg_write_r <= !dec.illegal && dec.dest != 5'd0;
      illegal_r   <= dec.illegal;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid      = out_valid_r;
  assign bus.reg1_data      = reg1_r;
  assign bus.reg2_data      = reg2_r;
  assign bus.immediate_data = imm_r;
  assign bus.shift_ammount  = shamt_r;
  assign bus.use_immediate  = use_imm_r;
  assign bus.shift_type     = shift_r;
  assign bus.alu_op         = alu_r;
  assign bus.dest_reg       = dest_r;
  assign bus.reg_write      = reg_write_r;
  assign bus.illegal        = illegal_r;
endmodule

`default_nettype wire

// File: doc/operand_decode.md
OPERAND_DECODE -- requirements
Module: operand_decode

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and there are 32 registers.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  instr is valid this cycle.
REQ-005 in_ready  out  1  block accepts instr this cycle.
REQ-006 instr  in  32  MIPS instruction word.
REQ-007 flush  in  1  discards the held output entry.
REQ-008 wb_en, wb_addr, wb_data  in  1/5/32  register-file write port.
REQ-009 out_valid  out  1  the decoded bundle is valid.
REQ-010 out_ready  in  1  the execute stage consumes the bundle.
REQ-011 reg1_data, reg2_data  out  32/32  rs and rt operand values.
REQ-012 immediate_data  out  32  extended immediate.
REQ-013 shift_ammount  out  5  shamt field.
REQ-014 use_immediate  out  1  selects immediate_data over reg2_data.
REQ-015 shift_type  out  3  bit0 = arithmetic, bit1 = right, bit2 = variable; 3'b001 means no shift.
REQ-016 alu_op, dest_reg, reg_write, illegal  out  4/5/1/1  ALU operation, destination register, write enable, unsupported-instruction flag.

Function
REQ-017 The output SHALL be a one-entry registered stage; in_ready = !out_valid || out_ready.
REQ-018 A capture SHALL occur when in_valid && in_ready; all outputs SHALL update on the next edge, giving 1-cycle latency.
REQ-019 out_valid SHALL clear on an edge where out_ready=1 and no capture occurs; the held outputs SHALL be stable while out_valid && !out_ready.
REQ-020 flush SHALL clear out_valid on the next edge and SHALL take priority over a simultaneous capture; the flushed instruction is lost.
REQ-021 For R-type instructions (opcode 0), the block SHALL decode funct as follows:
- sll, srl, sra → shift_type 000, 010, 011.
- sllv, srlv, srav → shift_type 100, 110, 111.
- add, addu, sub, subu, and, or, xor, nor, slt, sltu → shift_type 001 with the matching alu_op.
- dest_reg = rd; use_immediate = 0.
REQ-022 For I-type instructions, the block SHALL decode addi, addiu, slti, sltiu, andi, ori, xori and lui with use_immediate=1, shift_type 001 and dest_reg = rt.
REQ-023 The immediate SHALL be sign-extended, except andi/ori/xori, which zero-extend, and lui, which produces {imm16, 16'h0} with alu_op OR.
REQ-024 reg_write SHALL be 1 only for legal instructions with dest_reg != 0.
REQ-025 Any other opcode/funct SHALL set illegal=1, reg_write=0 and alu_op=ADD, with out_valid asserted normally.
REQ-026 reg1_data SHALL be read from rs and reg2_data from rt at capture; register 0 SHALL always read 0.
REQ-027 A wb_en write SHALL update the register file at the edge; writes to register 0 SHALL be ignored.
REQ-028 wb_en SHALL be honoured regardless of the in_valid, out_ready and flush states.

Reset
REQ-029 While rst=1 at an edge, the block SHALL:
- clear out_valid, reg1_data, reg2_data, immediate_data, shift_ammount, use_immediate, alu_op, dest_reg, reg_write and illegal to 0;
- set shift_type to 3'b001;
- clear all 32 registers to 0.
REQ-030 rst SHALL override a simultaneous capture, flush or wb_en write; the block SHALL accept instructions on the first edge after rst deasserts.

Configuration
REQ-031 With OPERAND_DECODE_WB_BYPASS_EN defined, a capture in the same cycle as wb_en with wb_addr == rs (or rt), addr != 0, SHALL output wb_data for that operand.
REQ-032 Without OPERAND_DECODE_WB_BYPASS_EN, that capture SHALL output the pre-write register value.

Structure
REQ-033 Package mips_pkg SHALL hold:
- the alu_op enum;
- the opcode and funct constants;
- the shift_type encodings.
REQ-034 The register file SHALL be a separate sub-module, register_file: 2 combinational read ports, 1 synchronous write port, synchronous reset.

Verification
REQ-035 Reset, then issue addi $t0,$zero,-5 (0x2008FFFB) -> one cycle later out_valid=1, immediate_data=0xFFFFFFFB, dest_reg=8, reg_write=1, shift_type=001.
REQ-036 Write $s1=0x80000000 via wb, then issue srav $t1,$s1,$s2 with $s2=4 -> reg1_data=4, reg2_data=0x80000000, shift_type=111, use_immediate=0.
REQ-037 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; raise out_ready -> next instruction captured on the same edge.
REQ-038 Assert flush together with a capture -> out_valid=0 next cycle; then issue an opcode 0x3F instruction -> illegal=1, reg_write=0.
REQ-039 Issue wb_en to $3=0x1234 in the same cycle as add reading $3 -> reg1_data=0x1234 with the bypass macro, 0 without it.
REQ-040 Assert rst mid-stream with out_valid=1 and wb_en=1 -> out_valid=0, shift_type=001 and the target register still reads 0.
